// File: rtl/ariane_pkg.sv
// Shared types and sizing for the issue scoreboard: entry record, exception record, default depth and port count.
// The optional forwarding path of the scoreboard is selected with ISSUE_SB_FORWARD_EN.
package ariane_pkg;

    localparam int NR_SB_ENTRIES = 8;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int NR_WB_PORTS   = 3;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_LSU,
        FU_MULT,
        FU_CSR,
        FU_BRANCH
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry;

    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        return 32'd1 << r;
    endfunction

endpackage

// File: rtl/issue_scoreboard_fwd_lookup.sv
// Age-ordered register match for the scoreboard forwarding path; only built when ISSUE_SB_FORWARD_EN is defined.
// Scans from the head towards the tail so the last hit is the youngest producer of the register.
`ifdef ISSUE_SB_FORWARD_EN
module sb_fwd_lookup
    import ariane_pkg::*;
#(
    parameter int NR_ENTRIES = NR_SB_ENTRIES
) (
    input  logic [NR_ENTRIES-1:0]                    i_occupied,
    input  logic [NR_ENTRIES-1:0][4:0]               i_rd,
    input  logic [NR_ENTRIES-1:0]                    i_valid,
    input  logic [NR_ENTRIES-1:0][63:0]              i_result,
    input  logic [$clog2(NR_ENTRIES)-1:0]            i_commit_ptr,
    input  logic [4:0]                               i_rs,
    output logic [63:0]                              o_data,
    output logic                                     o_valid
);

    localparam int IDW = $clog2(NR_ENTRIES);

    logic           w_hit;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_probe;

    always_comb begin
        w_hit   = 1'b0;
        w_idx   = '0;
        w_probe = '0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            w_probe = i_commit_ptr + IDW'(k);
            if (i_occupied[w_probe] && (i_rd[w_probe] == i_rs)) begin
                w_hit = 1'b1;
                w_idx = w_probe;
            end
        end
    end

    assign o_valid = w_hit && (i_rs != 5'd0) && i_valid[w_idx];
    assign o_data  = o_valid ? i_result[w_idx] : 64'd0;

endmodule
`endif

// File: rtl/issue_scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard as a circular buffer of scoreboard_entry.
// Define ISSUE_SB_FORWARD_EN to add the rs1/rs2 operand forwarding ports.
module issue_scoreboard
    import ariane_pkg::*;
#(
    parameter int NR_ENTRIES  = NR_SB_ENTRIES,
    parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    output logic                                          full_o,
    input  scoreboard_entry                               decoded_instr_i,
    input  logic                                          decoded_instr_valid_i,
    output logic                                          decoded_instr_ack_o,
    output logic [$clog2(NR_ENTRIES)-1:0]                 issue_trans_id_o,
    output logic [31:0]                                   rd_clobber_o,
    output scoreboard_entry                               commit_instr_o,
    output logic                                          commit_valid_o,
    input  logic                                          commit_ack_i,
    input  logic [NR_WB_PORTS-1:0][$clog2(NR_ENTRIES)-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]                  wb_data_i,
    input  exception_t [NR_WB_PORTS-1:0]                  wb_ex_i,
    input  logic [NR_WB_PORTS-1:0]                        wb_valid_i
`ifdef ISSUE_SB_FORWARD_EN
    ,
    input  logic [4:0]                                    rs1_i,
    input  logic [4:0]                                    rs2_i,
    output logic [63:0]                                   rs1_o,
    output logic                                          rs1_valid_o,
    output logic [63:0]                                   rs2_o,
    output logic                                          rs2_valid_o
`endif
);

    localparam int IDW = $clog2(NR_ENTRIES);

    scoreboard_entry       r_mem [NR_ENTRIES];
    scoreboard_entry       w_mem_n [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] r_occ;
    logic [NR_ENTRIES-1:0] w_occ_n;
    logic [IDW-1:0]        r_issue_ptr;
    logic [IDW-1:0]        r_commit_ptr;
    logic [IDW:0]          r_issue_cnt;
    logic                  w_issue;
    logic                  w_commit;
    logic [31:0]           w_clobber;

    // Full is taken from the registered count, so a retiring head never frees a slot in the same cycle.
    assign full_o              = (r_issue_cnt == (IDW+1)'(NR_ENTRIES));
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign w_issue             = decoded_instr_ack_o;
    assign issue_trans_id_o    = r_issue_ptr;

    assign commit_instr_o = r_mem[r_commit_ptr];
    assign commit_valid_o = r_occ[r_commit_ptr] & r_mem[r_commit_ptr].valid;
    assign w_commit       = commit_ack_i & commit_valid_o & ~flush_i;

    // Ascending port order lets the highest port win; issue is applied last so it beats writeback.
    always_comb begin
        w_mem_n = r_mem;
        w_occ_n = r_occ;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && r_occ[wb_trans_id_i[p]]) begin
                w_mem_n[wb_trans_id_i[p]].result = wb_data_i[p];
                w_mem_n[wb_trans_id_i[p]].valid  = 1'b1;
                if (wb_ex_i[p].valid) begin
                    w_mem_n[wb_trans_id_i[p]].ex = wb_ex_i[p];
                end
            end
        end
        if (w_commit) begin
            w_occ_n[r_commit_ptr] = 1'b0;
        end
        if (w_issue) begin
            w_mem_n[r_issue_ptr]          = decoded_instr_i;
            w_mem_n[r_issue_ptr].trans_id = TRANS_ID_BITS'(r_issue_ptr);
            w_mem_n[r_issue_ptr].valid    = 1'b0;
            w_occ_n[r_issue_ptr]          = 1'b1;
        end
        if (flush_i) begin
            w_occ_n = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
            r_occ        <= '0;
            r_issue_ptr  <= '0;
            r_commit_ptr <= '0;
            r_issue_cnt  <= '0;
        end else begin
            r_mem <= w_mem_n;
            r_occ <= w_occ_n;
            if (flush_i) begin
                r_issue_ptr  <= '0;
                r_commit_ptr <= '0;
                r_issue_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_ptr <= r_issue_ptr + IDW'(1);
                end
                if (w_commit) begin
                    r_commit_ptr <= r_commit_ptr + IDW'(1);
                end
                r_issue_cnt <= r_issue_cnt + (IDW+1)'(w_issue) - (IDW+1)'(w_commit);
            end
        end
    end

    always_comb begin
        w_clobber = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (r_occ[i]) begin
                w_clobber = w_clobber | reg_onehot(r_mem[i].rd);
            end
        end
    end

    assign rd_clobber_o = w_clobber & ~32'd1;

`ifdef ISSUE_SB_FORWARD_EN
    logic [NR_ENTRIES-1:0][4:0]  w_fwd_rd;
    logic [NR_ENTRIES-1:0]       w_fwd_valid;
    logic [NR_ENTRIES-1:0][63:0] w_fwd_result;

    always_comb begin
        w_fwd_rd     = '0;
        w_fwd_valid  = '0;
        w_fwd_result = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            w_fwd_rd[i]     = r_mem[i].rd;
            w_fwd_valid[i]  = r_mem[i].valid;
            w_fwd_result[i] = r_mem[i].result;
        end
    end

    sb_fwd_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_fwd_rs1 (
        .i_occupied   (r_occ),
        .i_rd         (w_fwd_rd),
        .i_valid      (w_fwd_valid),
        .i_result     (w_fwd_result),
        .i_commit_ptr (r_commit_ptr),
        .i_rs         (rs1_i),
        .o_data       (rs1_o),
        .o_valid      (rs1_valid_o)
    );

    sb_fwd_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_fwd_rs2 (
        .i_occupied   (r_occ),
        .i_rd         (w_fwd_rd),
        .i_valid      (w_fwd_valid),
        .i_result     (w_fwd_result),
        .i_commit_ptr (r_commit_ptr),
        .i_rs         (rs2_i),
        .o_data       (rs2_o),
        .o_valid      (rs2_valid_o)
    );
`else
    // No operand forwarding: consumers wait for commit.
`endif

endmodule
